fpu_issue_arbiter: RTL and testbench
====================================

// Module: fpu_issue_arbiter
// PURPOSE
//  Shares one FPU issue port between VLIW slot 1 (older) and slot 2 (younger) in the EX stage.
//  Arbitrates requests, gates unpipelined fdiv/fsqrt, and avoids result-port collisions.
//  Tracks in-flight ops in a completion shift table and tags each result with its slot and dst.
//  Drives the FPU op/select lines and the EX stall used to hold decode/EX registers.
// PARAMETERS
//  LAT_ADD    2  cycles grant->done, fadd/fsub (pipelined)
//  LAT_MUL    2  cycles, fmul (pipelined)
//  LAT_DIV    8  cycles, fdiv/fsqrt (unpipelined; blocks all issue)
//  LAT_OTHER  1  cycles, all other op codes (pipelined)
//  MAX_LAT    8  completion table depth; must be >= every LAT_*
// PORTS
//  clk        in   1  clock, rising edge
//  rstn       in   1  asynchronous active-low reset
//  flush      in   1  drop all in-flight and pending ops
//  req1/req2  in   1  slot 1/2 FPU request (FPUControl bit0 of that slot)
//  op1/op2    in   4  slot 1/2 FPU op (FPUControl[4:1])
//  dst1/dst2  in   6  slot 1/2 destination register
//  grant1/2   out  1  request issued this cycle (combinational)
//  fpu_valid  out  1  an op is issued to the FPU this cycle
//  fpu_sel    out  1  0: slot 1 operands, 1: slot 2 operands
//  fpu_op     out  4  op of the issued request (0 when none)
//  stall      out  1  some asserted request is not granted this cycle
//  done       out  1  a result leaves the FPU this cycle (registered)
//  done_slot  out  1  slot that owns the result
//  done_dst   out  6  destination of the result
//  busy       out  1  an unpipelined op is in progress
//  perf_issue out 32  issued-op count (see CONFIGURATION)
//  perf_stall out 32  stall-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Op classes: 0000 fadd and 0001 fsub take LAT_ADD. 0010 fmul takes LAT_MUL.
//    0011 fdiv and 0100 fsqrt take LAT_DIV. Any other code takes LAT_OTHER.
//  - Reset: every output is 0; the table is cleared; state is IDLE; the div counter is 0.
//  - States:
//    IDLE: issue allowed.
//    DIVB: div counter running; no grants.
//    PEND2: slot 2 was left waiting after a slot 1 grant.
//  - Transitions:
//    IDLE->DIVB on a div-class grant; the counter loads LAT_DIV-1.
//    DIVB->IDLE when the counter reaches 0. The next grant is possible exactly LAT_DIV cycles after the div grant.
//    IDLE->PEND2 when req1 and req2 are both asserted and slot 1 is granted.
//    PEND2->IDLE when slot 2 is granted (or ->DIVB if that op is div-class).
//  - Arbitration: at most one grant per cycle. Slot 1 has fixed priority, which preserves program order.
//    In PEND2 only slot 2 may be granted. Slot 1 is already retired and its req is ignored.
//  - Collision rule: an op with latency L is granted only if table position L is empty after this cycle's shift.
//    Otherwise it is held (stall=1) and retried the next cycle.
//  - Table: entry k = {valid, slot, dst}, completing k cycles after this edge.
//    Each edge shifts the table toward position 1. Position 1 drives done, done_slot and done_dst the next cycle.
//    A grant writes position L.
//  - Completion: done is asserted exactly L cycles after the grant edge, for one cycle per op.
//    Pipelined ops drain normally while DIVB is active.
//  - stall = (req1 & !grant1 & state!=PEND2) | (req2 & !grant2).
//    The requester holds req, op and dst stable while stall=1.
//  - flush: synchronous. It clears the table, the counter and the state (->IDLE) and forces grant=0 that cycle.
//    No done is produced for flushed ops. flush wins over a simultaneous request.
//  - rstn deasserted mid-operation: every op is discarded and no late done appears.
//    A request in the first cycle after reset is granted if its class is legal.
// CONFIGURATION
//  - FPU_ARB_PERF_EN defined: perf_issue increments by 1 on each fpu_valid cycle.
//    perf_stall increments by 1 on each stall cycle. Both counters wrap at 2^32.
//    Both are cleared by rstn and are not cleared by flush.
//  - FPU_ARB_PERF_EN undefined: perf_issue and perf_stall are constant 0 and no counter flops exist.
// TESTING
//  1. req1 fadd dst=5 at cycle 0 -> grant1=1, fpu_sel=0, stall=0; done=1, slot=0, dst=5 at cycle 2 only.
//  2. req1 fmul dst=3 and req2 fmul dst=4 at cycle 0 -> grant1@0 with stall=1; grant2@1 with stall=0;
//     done dst=3 @2, done dst=4 @3.
//  3. req1 fdiv dst=7 and req2 fadd dst=8 at cycle 0 -> busy=1 over cycles 1-7, stall=1 over cycles 0-7;
//     grant2@8; done dst=7 @8; done dst=8 @10.
//  4. fadd slot 1 @0, then fcmp (op 0110, lat 1) slot 1 @1 -> fcmp held @1 (stall=1), granted @2;
//     done @2 for the fadd and @3 for the fcmp, never both in one cycle.
//  5. fmul granted @0, flush @1 -> no done in cycles 2-3; a new fadd @1 is not granted;
//     the same fadd is granted @2.
//  6. rstn low @3 during an fdiv issued @0 -> all outputs 0 immediately; after release, fadd granted at once;
//     no fdiv done ever; with FPU_ARB_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter
//   Shares one FPU issue port between VLIW slot 1 (older) and slot 2
//   (younger) in the EX stage. Slot 1 has fixed priority. Unpipelined
//   fdiv/fsqrt block all issue until they finish. Each op reserves its
//   completion cycle in a shift table, so that two results never leave
//   the FPU in the same cycle.
//
//   Optional feature: define FPU_ARB_PERF_EN to build the issue and stall
//   performance counters. When it is undefined, both counters read 0 and
//   no counter flops exist.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   flush                synchronous drop of all in-flight and pending ops
//   req1/op1/dst1        slot 1 request, FPU op code, destination register
//   req2/op2/dst2        slot 2 request, FPU op code, destination register
//   grant1, grant2       request issued this cycle (combinational)
//   fpu_valid, fpu_sel   issue strobe; operand select (0 = slot 1, 1 = slot 2)
//   fpu_op               op code of the issued request (0 when nothing issues)
//   stall                an asserted request is not granted this cycle
//   done, done_slot,     a result leaves the FPU this cycle, with the slot
//   done_dst             and destination that own it (registered)
//   busy                 an unpipelined op is in progress (registered)
//   perf_issue,          issued-op and stall-cycle counters
//   perf_stall
module fpu_issue_arbiter #(
  parameter int LAT_ADD   = 2,
  parameter int LAT_MUL   = 2,
  parameter int LAT_DIV   = 8,
  parameter int LAT_OTHER = 1,
  parameter int MAX_LAT   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        req1,
  input  logic [3:0]  op1,
  input  logic [5:0]  dst1,
  input  logic        req2,
  input  logic [3:0]  op2,
  input  logic [5:0]  dst2,
  output logic        grant1,
  output logic        grant2,
  output logic        fpu_valid,
  output logic        fpu_sel,
  output logic [3:0]  fpu_op,
  output logic        stall,
  output logic        done,
  output logic        done_slot,
  output logic [5:0]  done_dst,
  output logic        busy,
  output logic [31:0] perf_issue,
  output logic [31:0] perf_stall
);

  localparam int LW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIVB  = 2'd1,
    S_PEND2 = 2'd2
  } state_t;

  // Latency class of an op code.
  function automatic logic [LW-1:0] op_lat(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001: op_lat = LW'(LAT_ADD);
      4'b0010:          op_lat = LW'(LAT_MUL);
      4'b0011, 4'b0100: op_lat = LW'(LAT_DIV);
      default:          op_lat = LW'(LAT_OTHER);
    endcase
  endfunction

  // fdiv and fsqrt are unpipelined.
  function automatic logic is_div(input logic [3:0] op);
    is_div = (op == 4'b0011) || (op == 4'b0100);
  endfunction

  // Position lat is free after this edge's shift when position lat+1 is
  // empty now. The deepest position is always refilled empty.
  function automatic logic slot_free(input logic [MAX_LAT:1] v, input logic [LW-1:0] lat);
    logic occ;
    occ = 1'b0;
    for (int k = 1; k < MAX_LAT; k++) begin
      occ = occ | ((lat == LW'(k)) & v[k+1]);
    end
    slot_free = ~occ;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [LW-1:0] cnt_r, cnt_nxt_s;
  logic          pend_r, pend_nxt_s;
  logic          busy_r;

  logic [MAX_LAT:1] tbl_v_r, tbl_s_r, tbl_v_nxt_s, tbl_s_nxt_s;
  logic [5:0]       tbl_d_r     [1:MAX_LAT];
  logic [5:0]       tbl_d_nxt_s [1:MAX_LAT];

  logic          grant1_s, grant2_s, issue_s, stall_s;
  logic          free1_s, free2_s;
  logic [LW-1:0] lat1_s, lat2_s, lat_g_s;
  logic [3:0]    op_g_s;
  logic [5:0]    dst_g_s;

  // Arbitration: slot 1 first in IDLE, only slot 2 in PEND2, none in DIVB.
  always_comb begin
    grant1_s = 1'b0;
    grant2_s = 1'b0;
    lat1_s   = op_lat(op1);
    lat2_s   = op_lat(op2);
    free1_s  = slot_free(tbl_v_r, lat1_s);
    free2_s  = slot_free(tbl_v_r, lat2_s);
    if (rstn && !flush) begin
      case (state_r)
        S_IDLE: begin
          // Slot 2 never overtakes a waiting slot 1 (program order).
          if (req1) begin
            grant1_s = free1_s;
          end else begin
            grant2_s = req2 & free2_s;
          end
        end
        S_PEND2: grant2_s = req2 & free2_s;
        S_DIVB:  grant2_s = 1'b0;
        default: grant2_s = 1'b0;
      endcase
    end else begin
      grant1_s = 1'b0;
      grant2_s = 1'b0;
    end
  end

  // Issue-side mux of the winning request.
  always_comb begin
    issue_s = grant1_s | grant2_s;
    op_g_s  = grant2_s ? op2 : op1;
    lat_g_s = grant2_s ? lat2_s : lat1_s;
    dst_g_s = grant2_s ? dst2 : dst1;
    stall_s = rstn & ((req1 & ~grant1_s & (state_r != S_PEND2)) | (req2 & ~grant2_s));
  end

  assign grant1    = grant1_s;
  assign grant2    = grant2_s;
  assign fpu_valid = issue_s;
  assign fpu_sel   = grant2_s;
  assign fpu_op    = issue_s ? op_g_s : 4'b0000;
  assign stall     = stall_s;

  // Next state, div counter and the "slot 2 still waiting after a div" flag.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pend_nxt_s  = pend_r;
    if (flush) begin
      state_nxt_s = S_IDLE;
      cnt_nxt_s   = '0;
      pend_nxt_s  = 1'b0;
    end else if (grant1_s) begin
      if (is_div(op1)) begin
        state_nxt_s = S_DIVB;
        cnt_nxt_s   = LW'(LAT_DIV - 1);
        pend_nxt_s  = req2;
      end else if (req2) begin
        state_nxt_s = S_PEND2;
      end else begin
        state_nxt_s = S_IDLE;
      end
    end else if (grant2_s) begin
      pend_nxt_s = 1'b0;
      if (is_div(op2)) begin
        state_nxt_s = S_DIVB;
        cnt_nxt_s   = LW'(LAT_DIV - 1);
      end else begin
        state_nxt_s = S_IDLE;
      end
    end else if (state_r == S_DIVB) begin
      // Leave on the edge where the counter reaches 0, so the next grant
      // lands exactly LAT_DIV cycles after the div grant.
      if (cnt_r <= LW'(1)) begin
        state_nxt_s = pend_r ? S_PEND2 : S_IDLE;
        cnt_nxt_s   = '0;
        pend_nxt_s  = 1'b0;
      end else begin
        cnt_nxt_s = cnt_r - LW'(1);
      end
    end else if ((state_r == S_PEND2) && !req2) begin
      state_nxt_s = S_IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Completion table: shift toward position 1, then reserve position L.
  always_comb begin
    tbl_v_nxt_s = '0;
    tbl_s_nxt_s = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      tbl_d_nxt_s[k] = 6'd0;
    end
    for (int k = 1; k < MAX_LAT; k++) begin
      tbl_v_nxt_s[k] = tbl_v_r[k+1];
      tbl_s_nxt_s[k] = tbl_s_r[k+1];
      tbl_d_nxt_s[k] = tbl_d_r[k+1];
    end
    for (int k = 1; k <= MAX_LAT; k++) begin
      tbl_v_nxt_s[k] = (issue_s && (lat_g_s == LW'(k))) ? 1'b1     : tbl_v_nxt_s[k];
      tbl_s_nxt_s[k] = (issue_s && (lat_g_s == LW'(k))) ? grant2_s : tbl_s_nxt_s[k];
      tbl_d_nxt_s[k] = (issue_s && (lat_g_s == LW'(k))) ? dst_g_s  : tbl_d_nxt_s[k];
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      pend_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pend_r  <= pend_nxt_s;
      busy_r  <= (state_nxt_s == S_DIVB);
    end
  end

  // Completion table registers; flush discards every in-flight op.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tbl_v_r <= '0;
      tbl_s_r <= '0;
      for (int k = 1; k <= MAX_LAT; k++) begin
        tbl_d_r[k] <= 6'd0;
      end
    end else if (flush) begin
      tbl_v_r <= '0;
      tbl_s_r <= '0;
      for (int k = 1; k <= MAX_LAT; k++) begin
        tbl_d_r[k] <= 6'd0;
      end
    end else begin
      tbl_v_r <= tbl_v_nxt_s;
      tbl_s_r <= tbl_s_nxt_s;
      for (int k = 1; k <= MAX_LAT; k++) begin
        tbl_d_r[k] <= tbl_d_nxt_s[k];
      end
    end
  end

  // Empty entries carry zero slot/dst, so the done fields read 0 when idle.
  assign done      = tbl_v_r[1];
  assign done_slot = tbl_s_r[1];
  assign done_dst  = tbl_d_r[1];
  assign busy      = busy_r;

`ifdef FPU_ARB_PERF_EN
  logic [31:0] perf_issue_r, perf_stall_r;

  // Free-running counters; flush does not clear them, wrap at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issue_r <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      perf_issue_r <= issue_s ? (perf_issue_r + 32'd1) : perf_issue_r;
      perf_stall_r <= stall_s ? (perf_stall_r + 32'd1) : perf_stall_r;
    end
  end

  assign perf_issue = perf_issue_r;
  assign perf_stall = perf_stall_r;
`else
  assign perf_issue = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed testbench for fpu_issue_arbiter. Inputs change 1 time unit
// after the rising edge. Outputs are sampled on the falling edge. The
// cycle numbers in the tags count from the first cycle of each scenario.
module tb_fpu_issue_arbiter;

  logic        clk, rstn, flush;
  logic        req1, req2;
  logic [3:0]  op1, op2;
  logic [5:0]  dst1, dst2;
  logic        grant1, grant2, fpu_valid, fpu_sel, stall;
  logic [3:0]  fpu_op;
  logic        done, done_slot, busy;
  logic [5:0]  done_dst;
  logic [31:0] perf_issue, perf_stall;

  int n_checks;
  int n_fail;

  fpu_issue_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .req1       (req1),
    .op1        (op1),
    .dst1       (dst1),
    .req2       (req2),
    .op2        (op2),
    .dst2       (dst2),
    .grant1     (grant1),
    .grant2     (grant2),
    .fpu_valid  (fpu_valid),
    .fpu_sel    (fpu_sel),
    .fpu_op     (fpu_op),
    .stall      (stall),
    .done       (done),
    .done_slot  (done_slot),
    .done_dst   (done_dst),
    .busy       (busy),
    .perf_issue (perf_issue),
    .perf_stall (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic r1, input logic [3:0] o1, input logic [5:0] d1,
                         input logic r2, input logic [3:0] o2, input logic [5:0] d2);
    req1 = r1; op1 = o1; dst1 = d1;
    req2 = r2; op2 = o2; dst2 = d2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_req(1'b0, 4'd0, 6'd0, 1'b0, 4'd0, 6'd0);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn  = 1'b0;
    flush = 1'b0;
    set_req(1'b0, 4'd0, 6'd0, 1'b0, 4'd0, 6'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset perf_issue", perf_issue, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // 1: single fadd from slot 1, done two cycles later only.
    set_req(1'b1, 4'd0, 6'd5, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t1 grant1 c0", {31'd0, grant1}, 32'd1);
    check("t1 sel c0", {31'd0, fpu_sel}, 32'd0);
    check("t1 stall c0", {31'd0, stall}, 32'd0);
    check("t1 valid c0", {31'd0, fpu_valid}, 32'd1);
    next_cycle();
    set_req(1'b0, 4'd0, 6'd0, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t1 done c1", {31'd0, done}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t1 done c2", {31'd0, done}, 32'd1);
    check("t1 slot c2", {31'd0, done_slot}, 32'd0);
    check("t1 dst c2", {26'd0, done_dst}, 32'd5);
    next_cycle();
    @(negedge clk);
    check("t1 done c3", {31'd0, done}, 32'd0);
    idle(3);

    // 2: two fmuls, slot 1 first, slot 2 the next cycle.
    set_req(1'b1, 4'd2, 6'd3, 1'b1, 4'd2, 6'd4);
    @(negedge clk);
    check("t2 grant1 c0", {31'd0, grant1}, 32'd1);
    check("t2 grant2 c0", {31'd0, grant2}, 32'd0);
    check("t2 stall c0", {31'd0, stall}, 32'd1);
    check("t2 op c0", {28'd0, fpu_op}, 32'd2);
    next_cycle();
    @(negedge clk);
    check("t2 grant2 c1", {31'd0, grant2}, 32'd1);
    check("t2 grant1 c1", {31'd0, grant1}, 32'd0);
    check("t2 stall c1", {31'd0, stall}, 32'd0);
    check("t2 sel c1", {31'd0, fpu_sel}, 32'd1);
    next_cycle();
    set_req(1'b0, 4'd0, 6'd0, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t2 done c2", {31'd0, done}, 32'd1);
    check("t2 dst c2", {26'd0, done_dst}, 32'd3);
    check("t2 slot c2", {31'd0, done_slot}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t2 done c3", {31'd0, done}, 32'd1);
    check("t2 dst c3", {26'd0, done_dst}, 32'd4);
    check("t2 slot c3", {31'd0, done_slot}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("t2 done c4", {31'd0, done}, 32'd0);
    idle(3);

    // 3: fdiv from slot 1 blocks the slot 2 fadd for LAT_DIV cycles.
    set_req(1'b1, 4'd3, 6'd7, 1'b1, 4'd0, 6'd8);
    @(negedge clk);
    check("t3 grant1 c0", {31'd0, grant1}, 32'd1);
    check("t3 stall c0", {31'd0, stall}, 32'd1);
    check("t3 busy c0", {31'd0, busy}, 32'd0);
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("t3 busy c%0d", c), {31'd0, busy}, 32'd1);
      check($sformatf("t3 stall c%0d", c), {31'd0, stall}, 32'd1);
      check($sformatf("t3 grant2 c%0d", c), {31'd0, grant2}, 32'd0);
      check($sformatf("t3 done c%0d", c), {31'd0, done}, 32'd0);
    end
    next_cycle();
    @(negedge clk);
    check("t3 grant2 c8", {31'd0, grant2}, 32'd1);
    check("t3 busy c8", {31'd0, busy}, 32'd0);
    check("t3 stall c8", {31'd0, stall}, 32'd0);
    check("t3 done c8", {31'd0, done}, 32'd1);
    check("t3 dst c8", {26'd0, done_dst}, 32'd7);
    next_cycle();
    set_req(1'b0, 4'd0, 6'd0, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t3 done c9", {31'd0, done}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t3 done c10", {31'd0, done}, 32'd1);
    check("t3 dst c10", {26'd0, done_dst}, 32'd8);
    check("t3 slot c10", {31'd0, done_slot}, 32'd1);
    idle(3);

    // 4: fcmp held one cycle to avoid colliding with the fadd result.
    set_req(1'b1, 4'd0, 6'd10, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t4 grant1 c0", {31'd0, grant1}, 32'd1);
    next_cycle();
    set_req(1'b1, 4'd6, 6'd11, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t4 grant1 c1", {31'd0, grant1}, 32'd0);
    check("t4 stall c1", {31'd0, stall}, 32'd1);
    check("t4 done c1", {31'd0, done}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t4 grant1 c2", {31'd0, grant1}, 32'd1);
    check("t4 stall c2", {31'd0, stall}, 32'd0);
    check("t4 done c2", {31'd0, done}, 32'd1);
    check("t4 dst c2", {26'd0, done_dst}, 32'd10);
    next_cycle();
    set_req(1'b0, 4'd0, 6'd0, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t4 done c3", {31'd0, done}, 32'd1);
    check("t4 dst c3", {26'd0, done_dst}, 32'd11);
    next_cycle();
    @(negedge clk);
    check("t4 done c4", {31'd0, done}, 32'd0);
    idle(3);

    // 5: flush drops an in-flight fmul and blocks a same-cycle request.
    set_req(1'b1, 4'd2, 6'd12, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t5 grant1 c0", {31'd0, grant1}, 32'd1);
    next_cycle();
    set_req(1'b1, 4'd0, 6'd13, 1'b0, 4'd0, 6'd0);
    flush = 1'b1;
    @(negedge clk);
    check("t5 grant1 c1", {31'd0, grant1}, 32'd0);
    check("t5 valid c1", {31'd0, fpu_valid}, 32'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("t5 grant1 c2", {31'd0, grant1}, 32'd1);
    check("t5 done c2", {31'd0, done}, 32'd0);
    next_cycle();
    set_req(1'b0, 4'd0, 6'd0, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t5 done c3", {31'd0, done}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t5 done c4", {31'd0, done}, 32'd1);
    check("t5 dst c4", {26'd0, done_dst}, 32'd13);
    idle(3);

    // 6: reset in the middle of an fdiv.
    set_req(1'b1, 4'd3, 6'd20, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t6 grant1 c0", {31'd0, grant1}, 32'd1);
    next_cycle();
    set_req(1'b0, 4'd0, 6'd0, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
    check("t6 busy c1", {31'd0, busy}, 32'd1);
    next_cycle();
    next_cycle();
    rstn = 1'b0;
    set_req(1'b1, 4'd0, 6'd21, 1'b0, 4'd0, 6'd0);
    #1;
    check("t6 rst busy", {31'd0, busy}, 32'd0);
    check("t6 rst grant1", {31'd0, grant1}, 32'd0);
    check("t6 rst valid", {31'd0, fpu_valid}, 32'd0);
    check("t6 rst stall", {31'd0, stall}, 32'd0);
    check("t6 rst done", {31'd0, done}, 32'd0);
    check("t6 rst perf_issue", perf_issue, 32'd0);
    check("t6 rst perf_stall", perf_stall, 32'd0);
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    check("t6 grant1 post", {31'd0, grant1}, 32'd1);
    check("t6 stall post", {31'd0, stall}, 32'd0);
    next_cycle();
    set_req(1'b0, 4'd0, 6'd0, 1'b0, 4'd0, 6'd0);
    @(negedge clk);
`ifdef FPU_ARB_PERF_EN
    check("t6 perf_issue", perf_issue, 32'd1);
`else
    check("t6 perf_issue", perf_issue, 32'd0);
`endif
    check("t6 perf_stall", perf_stall, 32'd0);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) begin
        next_cycle();
        @(negedge clk);
      end
      check($sformatf("t6 done p%0d", c), {31'd0, done}, (c == 2) ? 32'd1 : 32'd0);
      check($sformatf("t6 dst p%0d", c), {26'd0, done_dst}, (c == 2) ? 32'd21 : 32'd0);
      check($sformatf("t6 busy p%0d", c), {31'd0, busy}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
